// File: rtl/lsu_axil_master.sv
// lsu_axil_master: AXI4-Lite initiator for the LSU/IFU memory path.
// Takes one CPU load or store at a time from a valid/ready request port. It
// runs the AR/R or AW/W/B channels and returns a one-cycle response pulse.
//
// Optional macro: LSU_AXIL_TIMEOUT_EN adds a per-transaction watchdog. When
// the watchdog expires, the block completes the transaction with resp_err=1.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      CPU request handshake (ready only while idle)
//   req_wen/addr/wdata/wmask request payload (1=store)
//   resp_valid/rdata/err     single-cycle completion pulse
//   ar*/r*                   AXI4-Lite read address / read data channels
//   aw*/w*/b*                AXI4-Lite write address / data / response channels
module lsu_axil_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                req_ready_q, req_ready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

`ifdef LSU_AXIL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_c;
  logic                timeout_c;
`endif

  // Next state, payload capture and registered channel controls
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wmask;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen ? S_WREQ : S_RADDR;
        end
      end
      S_RADDR: begin
        if (arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (rvalid) begin
          resp_rdata_d = rdata;
          resp_err_d   = rresp[1];
          state_d      = S_DONE;
        end
      end
      S_WREQ: begin
        // AW and W complete independently; the flags remember each handshake
        if (awready) aw_done_d = 1'b1;
        if (wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (bvalid) begin
          resp_err_d = bresp[1];
          state_d    = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef LSU_AXIL_TIMEOUT_EN
    // Watchdog: a completion arriving on the expiry cycle still wins
    busy_c = (state_q == S_RADDR) || (state_q == S_RDATA) ||
             (state_q == S_WREQ)  || (state_q == S_WRESP);
    cnt_d  = '0;
    if (busy_c) begin
      cnt_d = (cnt_q == CNT_W'(TIMEOUT - 1)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    timeout_c = busy_c && (cnt_q == CNT_W'(TIMEOUT - 1)) && (state_d != S_DONE);
    if (timeout_c) begin
      state_d      = S_DONE;
      resp_rdata_d = '0;
      resp_err_d   = 1'b1;
    end
`endif

    // Outputs follow the state being entered so that they stay registered
    req_ready_d  = (state_d == S_IDLE);
    arvalid_d    = (state_d == S_RADDR);
    rready_d     = (state_d == S_RDATA);
    awvalid_d    = (state_d == S_WREQ) && !aw_done_d;
    wvalid_d     = (state_d == S_WREQ) && !w_done_d;
    bready_d     = (state_d == S_WRESP);
    resp_valid_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_AXIL_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef LSU_AXIL_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign araddr     = addr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awaddr     = addr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

  // Only bit 1 of a response code marks an error; TIMEOUT matters only with the watchdog
  logic unused_c;
`ifdef LSU_AXIL_TIMEOUT_EN
  assign unused_c = ^{rresp[0], bresp[0]};
`else
  assign unused_c = ^{rresp[0], bresp[0], TIMEOUT};
`endif

endmodule

// File: tb/tb_lsu_axil_master.sv
// Scoreboard bench for lsu_axil_master with a latency-configurable AXI4-Lite responder.
module tb_lsu_axil_master;

`ifdef LSU_AXIL_TIMEOUT_EN
  localparam int unsigned TMO  = 16;
  localparam int          LDLY = 4;
`else
  localparam int unsigned TMO  = 1024;
  localparam int          LDLY = 30;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wmask = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  lsu_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  typedef struct packed { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  exp_t        sb_q[$];
  logic [31:0] ar_q[$];
  wr_t         wr_q[$];

  int         cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
  logic [1:0] cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  bit         cfg_r_early = 1'b0;
  int         last_resp_cyc = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Read responder: AR ready after cfg_ar_dly, R valid after cfg_r_dly (or with AR if early)
  initial begin : rd_resp
    logic [31:0] a;
    int n;
    forever begin
      @(posedge clk); #1;
      if (arvalid && !rst) begin
        a = araddr;
        if (ar_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected: got %h want none", a);
        end else begin
          chk("araddr", 64'(a), 64'(ar_q.pop_front()));
        end
        for (int i = 0; i < cfg_ar_dly && !rst; i++) begin @(posedge clk); #1; end
        if (!rst) begin
          arready = 1'b1;
          if (cfg_r_early) begin rvalid = 1'b1; rdata = rd_model(a); rresp = cfg_rresp; end
          @(posedge clk); #1;
          arready = 1'b0;
          for (int i = 0; i < cfg_r_dly && !rst; i++) begin @(posedge clk); #1; end
          if (!rst) begin
            rvalid = 1'b1; rdata = rd_model(a); rresp = cfg_rresp;
            n = 0;
            while (!rready && !rst && n < 200) begin @(posedge clk); #1; n++; end
            if (n >= 200) begin
              checks++; errors++;
              $display("FAIL rready_wait: got timeout want rready");
            end else if (!rst) begin
              @(posedge clk); #1;
            end
          end
        end
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      end
    end
  end

  logic [31:0] aw_cap, w_cap_d;
  logic [3:0]  w_cap_s;
  bit          aw_got = 1'b0, w_got = 1'b0;

  initial begin : aw_resp
    forever begin
      @(posedge clk); #1;
      if (awvalid && !rst) begin
        aw_cap = awaddr;
        for (int i = 0; i < cfg_aw_dly && !rst; i++) begin @(posedge clk); #1; end
        if (!rst) begin
          awready = 1'b1;
          @(posedge clk); #1;
          awready = 1'b0;
          aw_got  = 1'b1;
        end
      end
    end
  end

  initial begin : w_resp
    forever begin
      @(posedge clk); #1;
      if (wvalid && !rst) begin
        w_cap_d = wdata; w_cap_s = wstrb;
        for (int i = 0; i < cfg_w_dly && !rst; i++) begin @(posedge clk); #1; end
        if (!rst) begin
          wready = 1'b1;
          @(posedge clk); #1;
          wready = 1'b0;
          w_got  = 1'b1;
        end
      end
    end
  end

  // Write response: evaluated at +2 so it sees AW/W handshakes from the same edge
  initial begin : b_resp
    wr_t e;
    int  n;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        aw_got = 1'b0; w_got = 1'b0;
      end else if (aw_got && w_got) begin
        aw_got = 1'b0; w_got = 1'b0;
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got %h want none", aw_cap);
        end else begin
          e = wr_q.pop_front();
          chk("awaddr", 64'(aw_cap), 64'(e.a));
          chk("wdata", 64'(w_cap_d), 64'(e.d));
          chk("wstrb", 64'(w_cap_s), 64'(e.s));
        end
        for (int i = 0; i < cfg_b_dly && !rst; i++) begin @(posedge clk); #2; end
        if (!rst) begin
          bvalid = 1'b1; bresp = cfg_bresp;
          n = 0;
          while (!bready && !rst && n < 200) begin @(posedge clk); #2; n++; end
          if (n >= 200) begin
            checks++; errors++;
            $display("FAIL bready_wait: got timeout want bready");
          end else if (!rst) begin
            @(posedge clk); #2;
          end
        end
        bvalid = 1'b0; bresp = 2'b00;
      end
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid pulse
  initial begin : resp_mon
    exp_t e;
    bit   prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (prev_rv) begin
          checks++; errors++;
          $display("FAIL resp_pulse_width: got 2+ cycles want 1");
        end
        last_resp_cyc = cyc;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got rdata %h err %b want none", resp_rdata, resp_err);
        end else begin
          e = sb_q.pop_front();
          chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          chk("resp_err", 64'(resp_err), 64'(e.err));
        end
      end
      prev_rv = resp_valid;
    end
  end

  // Payload stability: a valid without handshake must persist unchanged
  initial begin : stab_mon
    logic p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
    logic [31:0] p_ara = '0, p_awa = '0, p_wd = '0;
    logic [3:0]  p_ws = '0;
    forever begin
      @(negedge clk);
      if (!rst_seen && !resp_valid) begin
        if (p_arv && !p_arr) chk("ar_stable", 64'({arvalid, araddr}), 64'({1'b1, p_ara}));
        if (p_awv && !p_awr) chk("aw_stable", 64'({awvalid, awaddr}), 64'({1'b1, p_awa}));
        if (p_wv && !p_wr)   chk("w_stable", 64'({wvalid, wstrb, wdata}), 64'({1'b1, p_ws, p_wd}));
      end
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv  = wvalid;  p_wr  = wready;  p_wd  = wdata; p_ws = wstrb;
    end
  end

  // Issue one request; called and returns at a negedge, t_acc = acceptance edge index
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] wm, input logic [31:0] exp_rd, input logic exp_err,
                       input bit expect_resp, output int t_acc);
    int n;
    exp_t e;
    wr_t  w;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = wm;
    e.rdata = exp_rd; e.err = exp_err;
    if (expect_resp) sb_q.push_back(e);
    if (wen) begin w.a = addr; w.d = wd; w.s = wm; wr_q.push_back(w); end
    else ar_q.push_back(addr);
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: got timeout want req_ready");
    end
    @(posedge clk);
    @(negedge clk);
    t_acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin : stim
    int t;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid,
                               resp_err, resp_rdata}), 64'd0);
    chk("reset_payload", 64'({araddr, wstrb}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Zero-wait load: AR at T+1, response sampled at T+3
    issue(1'b0, 32'h8000_0004, '0, '0, 32'hDEAD_BEEF, 1'b0, 1'b1, t);
    chk("arvalid_t1", 64'({arvalid, araddr}), 64'({1'b1, 32'h8000_0004}));
    wait_idle(50);
    chk("load_latency", 64'(last_resp_cyc + 1 - t), 64'd3);

    // Store: W accepted 5 cycles before AW, B 3 cycles later
    cfg_aw_dly = 5; cfg_w_dly = 0; cfg_b_dly = 3;
    issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'h3, 32'h0, 1'b0, 1'b1, t);
    @(negedge clk);
    chk("w_drops_aw_held", 64'({awvalid, wvalid}), 64'b10);
    wait_idle(100);

    // Store with AW first and DECERR response
    cfg_aw_dly = 0; cfg_w_dly = 4; cfg_b_dly = 0; cfg_bresp = 2'b11;
    issue(1'b1, 32'h8000_0014, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 1'b1, t);
    wait_idle(100);
    cfg_w_dly = 0; cfg_bresp = 2'b00;

    // Zero-wait store latency: B at T+2, response sampled at T+3
    issue(1'b1, 32'h8000_0018, 32'hA5A5_0001, 4'h8, 32'h0, 1'b0, 1'b1, t);
    wait_idle(50);
    chk("store_latency", 64'(last_resp_cyc + 1 - t), 64'd3);

    // Load errors: SLVERR flags, EXOKAY does not
    cfg_rresp = 2'b10;
    issue(1'b0, 32'h8000_0008, '0, '0, rd_model(32'h8000_0008), 1'b1, 1'b1, t);
    wait_idle(50);
    cfg_rresp = 2'b01;
    issue(1'b0, 32'h8000_000C, '0, '0, rd_model(32'h8000_000C), 1'b0, 1'b1, t);
    wait_idle(50);
    cfg_rresp = 2'b00;

    // R presented together with the AR handshake
    cfg_ar_dly = 2; cfg_r_early = 1'b1;
    issue(1'b0, 32'h8000_0030, '0, '0, rd_model(32'h8000_0030), 1'b0, 1'b1, t);
    wait_idle(50);
    cfg_ar_dly = 0; cfg_r_early = 1'b0;

    // Back-to-back loads against a slow responder
    cfg_ar_dly = LDLY; cfg_r_dly = LDLY;
    for (int i = 0; i < 20; i++) begin
      a = 32'h1000_0000 + 32'(i * 4);
      issue(1'b0, a, '0, '0, rd_model(a), 1'b0, 1'b1, t);
    end
    wait_idle(5000);
    cfg_ar_dly = 0; cfg_r_dly = 0;

    // Reset during RDATA abandons the load silently
    cfg_r_dly = 20;
    issue(1'b0, 32'h8000_0020, '0, '0, '0, 1'b0, 1'b0, t);
    begin
      int n = 0;
      while (!rready && n < 100) begin @(negedge clk); n++; end
      chk("reached_rdata", 64'(rready), 64'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("outputs_after_reset", 64'({req_ready, arvalid, rready, awvalid, wvalid, bready,
                                     resp_valid, resp_err, resp_rdata}), 64'd0);
    cfg_r_dly = 0;
    repeat (3) @(negedge clk);
    issue(1'b0, 32'h8000_0024, '0, '0, rd_model(32'h8000_0024), 1'b0, 1'b1, t);
    wait_idle(50);

`ifdef LSU_AXIL_TIMEOUT_EN
    // AR never accepted: watchdog completes with an error
    cfg_ar_dly = 100000;
    issue(1'b0, 32'h8000_0040, '0, '0, 32'h0, 1'b1, 1'b1, t);
    wait_idle(100);
    chk("timeout_latency", 64'(last_resp_cyc - t), 64'd16);
    chk("timeout_ar_low", 64'({arvalid, rready}), 64'd0);
`endif

    repeat (5) @(negedge clk);
    chk("queues_empty", 64'(sb_q.size() + ar_q.size() + wr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
